// File: rtl/mem_read_align_pkg.sv
// Shared types for the data-memory load/store aligners: access size, load FSM states,
// and the legality check applied to an incoming load.
package mem_read_align_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b11
  } memsize_s;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } memrd_state_s;

  // Size code 2'b10 is never legal; halves need an even address and words need addr[1:0]==0.
  function automatic logic load_legal(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      2'b00:   load_legal = 1'b1;
      2'b01:   load_legal = ~lsb[0];
      2'b11:   load_legal = (lsb == 2'b00);
      default: load_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_read_align_extract.sv
// Combinational byte/half/word lane select with sign or zero extension of the
// selected field into a 32-bit load result.
module mem_read_extract
  import mem_read_align_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lsb,
  input  memsize_s    size,
  input  logic        is_signed,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lsb, 3'b000} +: 8];
    half_sel = lsb[1] ? word[31:16] : word[15:0];
    case (size)
      BYTE:    data = {{24{is_signed & byte_sel[7]}}, byte_sel};
      HALF:    data = {{16{is_signed & half_sel[15]}}, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_read_align.sv
// Load aligner: word-aligned read to data memory, wait for ack, extract/extend the result.
// Optional read watchdog enabled by defining MEM_RD_TIMEOUT_EN.
module mem_read_align
  import mem_read_align_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [31:0]  req_addr,
  input  logic [1:0]   req_size,
  input  logic         req_signed,
  output logic         mem_rd_en,
  output logic [31:0]  mem_addr,
  input  logic         mem_rd_ack,
  input  logic [31:0]  mem_rd_data,
  output logic         resp_valid,
  output logic [31:0]  resp_data,
  input  logic         resp_ready,
  output logic         align_except,
  output logic         bus_err,
  output memrd_state_s state_dbg
);

  // Handshakes: a request transfers on a rising edge where req_valid && req_ready; a response
  // transfers where resp_valid && resp_ready; resp_data is held stable until that transfer.

  if (2 ** CNT_W <= TIMEOUT_CYCLES) begin : g_bad_cnt_w
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end

  memrd_state_s state_q, state_d;
  logic [1:0]   lsb_q, lsb_d;
  memsize_s     size_q, size_d;
  logic         sign_q, sign_d;
  logic         mem_rd_en_q, mem_rd_en_d;
  logic [31:0]  mem_addr_q, mem_addr_d;
  logic         resp_valid_q, resp_valid_d;
  logic [31:0]  resp_data_q, resp_data_d;
  logic         align_except_q, align_except_d;
  logic [31:0]  ext_data;

`ifdef MEM_RD_TIMEOUT_EN
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             bus_err_q, bus_err_d;
`endif

  mem_read_extract u_extract (
    .word      (mem_rd_data),
    .lsb       (lsb_q),
    .size      (size_q),
    .is_signed (sign_q),
    .data      (ext_data)
  );

  always_comb begin
    state_d        = state_q;
    lsb_d          = lsb_q;
    size_d         = size_q;
    sign_d         = sign_q;
    mem_rd_en_d    = mem_rd_en_q;
    mem_addr_d     = mem_addr_q;
    resp_valid_d   = resp_valid_q;
    resp_data_d    = resp_data_q;
    align_except_d = 1'b0;
`ifdef MEM_RD_TIMEOUT_EN
    wd_d           = wd_q;
    bus_err_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (load_legal(req_size, req_addr[1:0])) begin
            state_d     = WAIT;
            lsb_d       = req_addr[1:0];
            size_d      = memsize_s'(req_size);
            sign_d      = req_signed;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_rd_en_d = 1'b1;
`ifdef MEM_RD_TIMEOUT_EN
            wd_d        = '0;
`endif
          end else begin
            align_except_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (mem_rd_ack) begin
          resp_data_d  = ext_data;
          resp_valid_d = 1'b1;
          mem_rd_en_d  = 1'b0;
          state_d      = RESP;
        end
`ifdef MEM_RD_TIMEOUT_EN
        // An ack arriving on the limit cycle takes priority over the timeout.
        else if (wd_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          bus_err_d   = 1'b1;
          mem_rd_en_d = 1'b0;
          state_d     = IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q        <= IDLE;
      lsb_q          <= 2'b00;
      size_q         <= BYTE;
      sign_q         <= 1'b0;
      mem_rd_en_q    <= 1'b0;
      mem_addr_q     <= '0;
      resp_valid_q   <= 1'b0;
      resp_data_q    <= '0;
      align_except_q <= 1'b0;
`ifdef MEM_RD_TIMEOUT_EN
      wd_q           <= '0;
      bus_err_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      lsb_q          <= lsb_d;
      size_q         <= size_d;
      sign_q         <= sign_d;
      mem_rd_en_q    <= mem_rd_en_d;
      mem_addr_q     <= mem_addr_d;
      resp_valid_q   <= resp_valid_d;
      resp_data_q    <= resp_data_d;
      align_except_q <= align_except_d;
`ifdef MEM_RD_TIMEOUT_EN
      wd_q           <= wd_d;
      bus_err_q      <= bus_err_d;
`endif
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign mem_rd_en    = mem_rd_en_q;
  assign mem_addr     = mem_addr_q;
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign align_except = align_except_q;
  assign state_dbg    = state_q;
`ifdef MEM_RD_TIMEOUT_EN
  assign bus_err      = bus_err_q;
`else
  assign bus_err      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_read_align.sv
// Directed bench for mem_read_align: extraction cases, illegal loads, stalls, reset mid-load
// and the watchdog (MEM_RD_TIMEOUT_EN) or its absence.
module tb_mem_read_align;
  import mem_read_align_pkg::*;

  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst_b = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [31:0]  req_addr = '0;
  logic [1:0]   req_size = 2'b00;
  logic         req_signed = 1'b0;
  logic         mem_rd_en;
  logic [31:0]  mem_addr;
  logic         mem_rd_ack = 1'b0;
  logic [31:0]  mem_rd_data = '0;
  logic         resp_valid;
  logic [31:0]  resp_data;
  logic         resp_ready = 1'b0;
  logic         align_except;
  logic         bus_err;
  memrd_state_s state_dbg;

  int checks = 0;
  int errors = 0;

  mem_read_align #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_ack   (mem_rd_ack),
    .mem_rd_data  (mem_rd_data),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_ready   (resp_ready),
    .align_except (align_except),
    .bus_err      (bus_err),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (req_ready !== 1'b1 || mem_rd_en !== 1'b0 || mem_addr !== 32'h0 || resp_valid !== 1'b0 ||
        resp_data !== 32'h0 || align_except !== 1'b0 || bus_err !== 1'b0 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL reset: rdy=%b en=%b addr=%h rv=%b rd=%h ae=%b be=%b st=%0d, exp 1 0 0 0 0 0 0 IDLE",
               req_ready, mem_rd_en, mem_addr, resp_valid, resp_data, align_except, bus_err, state_dbg);
    end
    tick();
    rst_b = 1'b1;
    tick();
  endtask

  // One complete load: request, ack_wait cycles of WAIT (ack on the last), hold cycles with
  // resp_ready low, then the response handshake.
  task automatic run_load(input string name, input logic [31:0] addr, input logic [1:0] size,
                          input logic sgn, input logic [31:0] rdata, input int ack_wait,
                          input int hold, input logic [31:0] exp);
    req_valid = 1'b1; req_addr = addr; req_size = size; req_signed = sgn;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s req_ready: got %b exp 1", name, req_ready);
    end
    tick();
    req_valid = 1'b0;
    checks++;
    if (mem_addr !== {addr[31:2], 2'b00}) begin
      errors++; $display("FAIL %s mem_addr: got %h exp %h", name, mem_addr, {addr[31:2], 2'b00});
    end
    for (int i = 1; i <= ack_wait; i++) begin
      checks++;
      if (mem_rd_en !== 1'b1 || state_dbg !== WAIT || resp_valid !== 1'b0 || bus_err !== 1'b0) begin
        errors++;
        $display("FAIL %s wait%0d: en=%b st=%0d rv=%b be=%b exp 1 WAIT 0 0",
                 name, i, mem_rd_en, state_dbg, resp_valid, bus_err);
      end
      mem_rd_ack  = (i == ack_wait);
      mem_rd_data = (i == ack_wait) ? rdata : 32'hA5A5_A5A5;
      tick();
    end
    mem_rd_ack = 1'b0; mem_rd_data = ~rdata;
    for (int i = 0; i <= hold; i++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== exp || mem_rd_en !== 1'b0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s resp%0d: rv=%b data=%h en=%b rdy=%b exp 1 %h 0 0",
                 name, i, resp_valid, resp_data, mem_rd_en, req_ready, exp);
      end
      resp_ready = (i == hold);
      tick();
    end
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL %s done: rv=%b rdy=%b st=%0d exp 0 1 IDLE", name, resp_valid, req_ready, state_dbg);
    end
  endtask

  task automatic test_extract();
    run_load("lb_neg",   32'h0000_0103, 2'b00, 1'b1, 32'h80FF_1234, 1, 0, 32'hFFFF_FF80);
    run_load("lhu",      32'h0000_0202, 2'b01, 1'b0, 32'hBEEF_0001, 1, 0, 32'h0000_BEEF);
    run_load("lh_hi",    32'h0000_0202, 2'b01, 1'b1, 32'hBEEF_0001, 1, 0, 32'hFFFF_BEEF);
    run_load("lh_lo",    32'h0000_0300, 2'b01, 1'b1, 32'h0001_8000, 2, 0, 32'hFFFF_8000);
    run_load("lbu_neg",  32'h0000_0102, 2'b00, 1'b0, 32'h80FF_1234, 1, 1, 32'h0000_00FF);
    run_load("lb_pos",   32'h0000_0101, 2'b00, 1'b1, 32'h80FF_1234, 1, 0, 32'h0000_0012);
    run_load("lw_sgn",   32'hFFFF_FFF8, 2'b11, 1'b1, 32'h8765_4321, 1, 0, 32'h8765_4321);
  endtask

  task automatic test_stall();
    run_load("lw_stall", 32'h0000_0000, 2'b11, 1'b0, 32'hCAFE_F00D, 5, 3, 32'hCAFE_F00D);
  endtask

  task automatic test_misaligned(input string name, input logic [31:0] addr, input logic [1:0] size);
    req_valid = 1'b1; req_addr = addr; req_size = size; req_signed = 1'b1;
    tick();
    req_valid = 1'b0;
    checks++;
    if (align_except !== 1'b1 || mem_rd_en !== 1'b0 || req_ready !== 1'b1 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL %s pulse: ae=%b en=%b rdy=%b st=%0d exp 1 0 1 IDLE",
               name, align_except, mem_rd_en, req_ready, state_dbg);
    end
    tick();
    checks++;
    if (align_except !== 1'b0 || mem_rd_en !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s after: ae=%b en=%b rv=%b exp 0 0 0", name, align_except, mem_rd_en, resp_valid);
    end
  endtask

  task automatic test_stray_inputs();
    mem_rd_ack = 1'b1; mem_rd_data = 32'h1234_5678; resp_ready = 1'b1;
    tick();
    tick();
    mem_rd_ack = 1'b0; resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || mem_rd_en !== 1'b0 || state_dbg !== IDLE || resp_data === 32'h1234_5678) begin
      errors++;
      $display("FAIL stray_idle: rv=%b en=%b st=%0d data=%h exp 0 0 IDLE not 12345678",
               resp_valid, mem_rd_en, state_dbg, resp_data);
    end
  endtask

  task automatic test_reset_mid_wait();
    req_valid = 1'b1; req_addr = 32'h0000_0404; req_size = 2'b11; req_signed = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    rst_b = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || mem_rd_en !== 1'b0 || mem_addr !== 32'h0 || resp_valid !== 1'b0 ||
        resp_data !== 32'h0 || align_except !== 1'b0 || bus_err !== 1'b0 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL rst_mid_wait: rdy=%b en=%b addr=%h rv=%b rd=%h st=%0d exp 1 0 0 0 0 IDLE",
               req_ready, mem_rd_en, mem_addr, resp_valid, resp_data, state_dbg);
    end
    tick();
    rst_b = 1'b1;
    mem_rd_ack = 1'b1; mem_rd_data = 32'hFFFF_FFFF;
    tick();
    mem_rd_ack = 1'b0;
    tick();
    checks++;
    if (resp_valid !== 1'b0 || state_dbg !== IDLE || resp_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_stray_ack: rv=%b st=%0d data=%h exp 0 IDLE 0", resp_valid, state_dbg, resp_data);
    end
  endtask

`ifdef MEM_RD_TIMEOUT_EN
  task automatic test_timeout();
    req_valid = 1'b1; req_addr = 32'h0000_0500; req_size = 2'b11; req_signed = 1'b0;
    tick();
    req_valid = 1'b0;
    for (int i = 1; i < TO; i++) tick();
    checks++;
    if (mem_rd_en !== 1'b1 || bus_err !== 1'b0) begin
      errors++; $display("FAIL timeout_pre: en=%b be=%b exp 1 0", mem_rd_en, bus_err);
    end
    tick();
    checks++;
    if (bus_err !== 1'b1 || mem_rd_en !== 1'b0 || state_dbg !== IDLE || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_hit: be=%b en=%b st=%0d rv=%b exp 1 0 IDLE 0", bus_err, mem_rd_en, state_dbg, resp_valid);
    end
    tick();
    checks++;
    if (bus_err !== 1'b0 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL timeout_after: be=%b rv=%b exp 0 0", bus_err, resp_valid);
    end
    run_load("ack_at_limit", 32'h0000_0600, 2'b11, 1'b0, 32'h0BAD_CAFE, TO, 0, 32'h0BAD_CAFE);
  endtask
`else
  task automatic test_no_timeout();
    run_load("long_wait", 32'h0000_0600, 2'b11, 1'b0, 32'h0BAD_CAFE, 3 * TO, 0, 32'h0BAD_CAFE);
  endtask
`endif

  initial begin
    test_reset();
    test_extract();
    test_stall();
    test_misaligned("lh_odd", 32'h0000_0201, 2'b01);
    test_misaligned("size10", 32'h0000_0201, 2'b10);
    test_misaligned("size10_al", 32'h0000_0200, 2'b10);
    test_misaligned("lw_mis", 32'h0000_0202, 2'b11);
    run_load("after_except", 32'h0000_0201, 2'b00, 1'b0, 32'h0000_7700, 1, 0, 32'h0000_0077);
    test_stray_inputs();
`ifdef MEM_RD_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
